// File: rtl/seg7_scan_display_if.sv
// Signal bundle between the counter-value producer and the 8-digit scan display.
// The producer is the master; the display driver is the slave.
interface seg7_scan_display_if;
  logic [31:0] value;
  logic        freeze;
  logic        blank_lz;
  logic [7:0]  an;
  logic [7:0]  seg;

  modport master (output value, output freeze, output blank_lz, input an, input seg);
  modport slave  (input value, input freeze, input blank_lz, output an, output seg);
endinterface

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 8-digit hex display of a 32-bit value, with one tear-free
// snapshot per scan frame, optional freeze and optional leading-zero blanking.
module seg7_scan_display #(
  parameter int SCAN_DIV = 100000,
  parameter int DIV_W    = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  seg7_scan_display_if.slave   bus
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       dig_q, dig_d;
  logic [31:0]      snap_q, snap_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;

  logic             tick;
  logic [3:0]       nib;
  logic [7:0]       lz;
  logic             dark;

  // Active-low segments g..a for one hex digit; dp is added by the caller.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // NOTE: every signal in this block is assigned on every path, so no latch is inferred.
  always_comb begin
    tick   = (div_q == DIV_LAST);
    div_d  = tick ? '0 : div_q + 1'b1;
    dig_d  = tick ? dig_q + 3'd1 : dig_q;
    // Capture only at the frame boundary, on the same edge dig wraps to 0.
    snap_d = (tick && dig_q == 3'd7 && !bus.freeze) ? bus.value : snap_q;

    nib = snap_q[4*dig_q +: 4];
    for (int d = 0; d < 8; d++) begin
      lz[d] = (d != 0) && ((snap_q >> (4 * d)) == 32'd0);
    end
    dark  = bus.blank_lz && lz[dig_q];

    an_d  = dark ? 8'hFF : ~(8'b1 << dig_q);
    seg_d = dark ? 8'hFF : {1'b1, hex7(nib)};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      dig_q  <= 3'd0;
      snap_q <= 32'd0;
      an_q   <= 8'hFF;
      seg_q  <= 8'hFF;
    end else begin
      div_q  <= div_d;
      dig_q  <= dig_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with SCAN_DIV=4: reset, scanning,
// freeze, leading-zero blanking, asynchronous reset and frame wrap.
module tb_seg7_scan_display;

  localparam int SCAN_DIV = 4;
  localparam int DIV_W    = 3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  seg7_scan_display_if bus ();

  seg7_scan_display #(.SCAN_DIV(SCAN_DIV), .DIV_W(DIV_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Advance to the negedge following posedge number k after reset release.
  task automatic goto(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Check every cycle k in [k0,k1] against the scan of word.
  task automatic check_slots(input int k0, input int k1, input logic [31:0] word,
                             input logic blank, input string name);
    int         d;
    logic       dk;
    logic [7:0] exp_an, exp_seg;
    for (int k = k0; k <= k1; k++) begin
      goto(k);
      d       = ((k - 1) / SCAN_DIV) % 8;
      dk      = blank && (d != 0) && ((word >> (4 * d)) == 32'd0);
      exp_an  = dk ? 8'hFF : ~(8'b1 << d);
      exp_seg = dk ? 8'hFF : hex_tab[word[4*d +: 4]];
      checks++;
      if (bus.an !== exp_an || bus.seg !== exp_seg) begin
        errors++;
        $display("FAIL %s k=%0d: an=%h seg=%h, required an=%h seg=%h",
                 name, k, bus.an, bus.seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic check_now(input logic [7:0] exp_an, input logic [7:0] exp_seg,
                           input string name);
    checks++;
    if (bus.an !== exp_an || bus.seg !== exp_seg) begin
      errors++;
      $display("FAIL %s: an=%h seg=%h, required an=%h seg=%h",
               name, bus.an, bus.seg, exp_an, exp_seg);
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.value    = 32'd0;
    bus.freeze   = 1'b0;
    bus.blank_lz = 1'b0;
    #2;
    check_now(8'hFF, 8'hFF, "reset_dark_no_clock");
    repeat (3) @(negedge clk);
    check_now(8'hFF, 8'hFF, "reset_dark_held");
    rst = 1'b0;
    cyc = 0;
    goto(1);
    check_now(8'hFE, 8'hC0, "reset_release_digit0");
    goto(4);
    check_now(8'hFE, 8'hC0, "digit0_held_4_cycles");
    goto(5);
    check_now(8'hFD, 8'hC0, "digit1_after_4_cycles");
  endtask

  task automatic test_scan();
    bus.value = 32'h1234ABCD;
    check_slots(6, 32, 32'd0, 1'b0, "frame0_shows_zero");
    check_slots(33, 64, 32'h1234ABCD, 1'b0, "scan_1234ABCD");
  endtask

  task automatic test_freeze();
    goto(70);
    bus.freeze = 1'b1;
    bus.value  = 32'hFFFFFFFF;
    check_slots(71, 150, 32'h1234ABCD, 1'b0, "frozen_frames");
    bus.freeze = 1'b0;
    check_slots(151, 160, 32'h1234ABCD, 1'b0, "unfreeze_wait_boundary");
    check_slots(161, 192, 32'hFFFFFFFF, 1'b0, "after_unfreeze_all_F");
  endtask

  task automatic test_blank_lz();
    bus.blank_lz = 1'b1;
    bus.value    = 32'h000000A5;
    check_slots(193, 224, 32'hFFFFFFFF, 1'b1, "blank_no_leading_zero");
    check_slots(225, 230, 32'h000000A5, 1'b1, "blank_A5");
    bus.value = 32'd0;
    check_slots(231, 256, 32'h000000A5, 1'b1, "blank_A5_tail");
    check_slots(257, 288, 32'd0, 1'b1, "blank_all_zero");
    bus.blank_lz = 1'b0;
    check_slots(289, 295, 32'd0, 1'b0, "unblank_zero");
  endtask

  task automatic test_async_reset();
    bus.value = 32'h12345678;
    goto(301);
    #2;
    rst = 1'b1;
    #1;
    check_now(8'hFF, 8'hFF, "async_reset_between_edges");
    repeat (2) @(negedge clk);
    check_now(8'hFF, 8'hFF, "async_reset_held");
    rst = 1'b0;
    cyc = 0;
    check_slots(1, 31, 32'd0, 1'b0, "restart_snap_zero");
  endtask

  task automatic test_wrap();
    bus.value = 32'h9ABCDEF7;
    goto(32);
    check_now(8'h7F, 8'hC0, "wrap_last_slot_old_snap");
    goto(33);
    check_now(8'hFE, 8'hF8, "wrap_first_slot_new_snap");
    bus.value = 32'h0;
    check_slots(34, 64, 32'h9ABCDEF7, 1'b0, "wrap_frame_9ABCDEF7");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    test_reset();
    test_scan();
    test_freeze();
    test_blank_lz();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
